rom_download_sequencer: RTL and testbench
=========================================

// Module: rom_download_sequencer
// PURPOSE
//  Sequences the HPS ROM download into the game core: pipelines ioctl bytes onto the
//  core's dn_addr/dn_data/dn_wr bus and decodes a ROM region per byte.
//  Holds the core in reset during download and for RST_HOLD cycles after it.
//  Releases the core only after a complete download (byte count == TOTAL_BYTES).
//  Sits between hps_io and the game core; also owns stretching of user reset.
// PARAMETERS
//  TOTAL_BYTES  16'hE0A0  exact byte count of a valid ROM set
//  CPU_END      16'h8000  first address past main-CPU ROM region
//  SND_END      16'hA000  first address past sound-CPU ROM region
//  GFX_END      16'hE000  first address past gfx ROM region; [GFX_END,TOTAL_BYTES) = PROM
//  RST_HOLD     16        reset-stretch cycles after download end or user reset
// PORTS
//  clk_sys         in   1   system clock; all logic on rising edge
//  reset_n         in   1   asynchronous active-low reset
//  ioctl_download  in   1   HPS download in progress
//  ioctl_wr        in   1   one-cycle byte strobe
//  ioctl_addr      in   25  byte address
//  ioctl_dout      in   8   byte data
//  user_reset      in   1   OR of menu/button reset requests (level)
//  dn_addr         out  16  core download address
//  dn_data         out  8   core download data
//  dn_wr           out  1   core write strobe
//  dn_region       out  4   one-hot region of current dn_wr: {prom,gfx,snd,cpu}
//  core_reset      out  1   active-high reset to game core
//  rom_ok          out  1   last finished download was complete and in range
//  dl_error        out  1   last finished download was short, long or out of range
// BEHAVIOUR
//  Reset values: dn_*=0, dn_region=0, core_reset=1, rom_ok=0, dl_error=0, state=IDLE.
//  States: IDLE (no valid ROM), LOAD, HOLD, RUN.
//  - IDLE: core_reset=1. ioctl_download rising edge -> LOAD.
//  - LOAD: core_reset=1; byte_cnt cleared on entry; rom_ok, dl_error cleared on entry.
//    Each ioctl_wr with ioctl_addr<TOTAL_BYTES: next cycle dn_wr=1 (exactly 1 cycle),
//    dn_addr=ioctl_addr[15:0], dn_data=ioctl_dout, dn_region decoded. Latency 1 clk.
//    ioctl_wr with ioctl_addr>=TOTAL_BYTES: dropped (no dn_wr), sets overflow flag.
//    byte_cnt (17 bit) increments per accepted write, saturates at 17'h1FFFF.
//    ioctl_download falling edge: if byte_cnt==TOTAL_BYTES and no overflow ->
//    rom_ok=1, load hold counter with RST_HOLD-1, -> HOLD; else dl_error=1 -> IDLE.
//    A write coinciding with the falling edge is accepted and counted first.
//  - HOLD: core_reset=1, counter decrements each cycle; at 0 -> RUN.
//    user_reset high reloads counter (reset stretch). ioctl_download rise -> LOAD.
//  - RUN: core_reset=0. user_reset high -> HOLD with counter=RST_HOLD-1
//    (core_reset rises the cycle after user_reset). ioctl_download rise -> LOAD.
//  Edge detect on ioctl_download uses one registered copy; download high out of
//  reset counts as a rising edge. dn_region=0 whenever dn_wr=0.
//  reset_n low at any time: immediate return to reset values, incl. mid-download;
//  bytes already written stay in core RAM but rom_ok=0 keeps the core in reset.
// STRUCTURE
//  Shared package (arcade_dl_pkg): state enum dl_state_t, region one-hot constants
//  REG_CPU/REG_SND/REG_GFX/REG_PROM, default TOTAL_BYTES per game.
//  One natural sub-module: dl_region_decode (combinational addr -> one-hot region).
//  FSM, byte counter, hold counter and output pipeline register in this module.
// TESTING
//  1. Full download 0..E09F, one wr per 4 clks -> E0A0 dn_wr pulses, each 1 clk after
//     ioctl_wr, addr/data match; rom_ok=1; core_reset falls exactly 16 clks after fall.
//  2. Region decode: wr at 7FFF,8000,9FFF,A000,DFFF,E000 -> dn_region
//     1,2,2,4,4,8 respectively.
//  3. Short download (stop at E09E) -> dl_error=1, rom_ok=0, core_reset stays 1 forever.
//  4. Write at E0A0 inside otherwise full download -> no dn_wr for it, dl_error=1.
//  5. In RUN pulse user_reset 1 clk -> core_reset high 16 clks; hold user_reset 40 clks
//     -> core_reset high until 16 clks after it drops.
//  6. reset_n low mid-LOAD at addr 3000 -> all outputs at reset values same cycle;
//     after reset_n high with download still high -> LOAD entered, byte_cnt restarts at 0.

Source files
------------

// File: rtl/arcade_dl_pkg.sv
// rtl/arcade_dl_pkg.sv - shared types and defaults for the ROM download sequencer
package arcade_dl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN
  } dl_state_t;

  localparam logic [3:0] REG_NONE = 4'b0000;
  localparam logic [3:0] REG_CPU  = 4'b0001;
  localparam logic [3:0] REG_SND  = 4'b0010;
  localparam logic [3:0] REG_GFX  = 4'b0100;
  localparam logic [3:0] REG_PROM = 4'b1000;

  localparam logic [15:0] DEF_TOTAL_BYTES = 16'hE0A0;
  localparam logic [15:0] DEF_CPU_END     = 16'h8000;
  localparam logic [15:0] DEF_SND_END     = 16'hA000;
  localparam logic [15:0] DEF_GFX_END     = 16'hE000;
  localparam int          DEF_RST_HOLD    = 16;

endpackage

// File: rtl/dl_region_decode.sv
// rtl/dl_region_decode.sv - combinational byte address to one-hot ROM region
module dl_region_decode
  import arcade_dl_pkg::*;
#(
  parameter logic [15:0] CPU_END = DEF_CPU_END,
  parameter logic [15:0] SND_END = DEF_SND_END,
  parameter logic [15:0] GFX_END = DEF_GFX_END
) (
  input  logic [15:0] addr,
  output logic [3:0]  region
);

  // Everything at or past GFX_END is PROM; the caller filters addresses past the ROM set.
  always_comb begin
    region = REG_PROM;
    if (addr < CPU_END)      region = REG_CPU;
    else if (addr < SND_END) region = REG_SND;
    else if (addr < GFX_END) region = REG_GFX;
  end

endmodule

// File: rtl/rom_download_sequencer.sv
// rtl/rom_download_sequencer.sv - ioctl-to-core download pipeline and core reset sequencing
module rom_download_sequencer
  import arcade_dl_pkg::*;
#(
  parameter logic [15:0] TOTAL_BYTES = DEF_TOTAL_BYTES,
  parameter logic [15:0] CPU_END     = DEF_CPU_END,
  parameter logic [15:0] SND_END     = DEF_SND_END,
  parameter logic [15:0] GFX_END     = DEF_GFX_END,
  parameter int          RST_HOLD    = DEF_RST_HOLD
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        user_reset,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic        dn_wr,
  output logic [3:0]  dn_region,
  output logic        core_reset,
  output logic        rom_ok,
  output logic        dl_error
);

  localparam logic [15:0] HOLD_LOAD = 16'(RST_HOLD - 1);
  localparam logic [24:0] TOTAL_EXT = {9'd0, TOTAL_BYTES};
  localparam logic [16:0] CNT_FULL  = {1'b0, TOTAL_BYTES};

  dl_state_t   state;
  logic        dl_q;
  logic [16:0] byte_cnt;
  logic        overflow;
  logic [15:0] hold_cnt;
  logic [3:0]  region;

  logic        dl_rise;
  logic        dl_fall;
  logic        in_load;
  logic        in_range;
  logic        accept;
  logic        reject;
  logic [16:0] cnt_next;
  logic        ovf_next;

  assign dl_rise  = ioctl_download & ~dl_q;
  assign dl_fall  = ~ioctl_download & dl_q;
  assign in_load  = (state == ST_LOAD);
  assign in_range = (ioctl_addr < TOTAL_EXT);
  assign accept   = in_load & ioctl_wr & in_range;
  assign reject   = in_load & ioctl_wr & ~in_range;

  // Counter and overflow as they stand after this cycle's write, so a write on the
  // falling edge of download is part of the completeness decision.
  assign cnt_next = (accept && byte_cnt != 17'h1FFFF) ? byte_cnt + 17'd1 : byte_cnt;
  assign ovf_next = overflow | reject;

  dl_region_decode #(
    .CPU_END (CPU_END),
    .SND_END (SND_END),
    .GFX_END (GFX_END)
  ) u_region (
    .addr   (ioctl_addr[15:0]),
    .region (region)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      dl_q       <= 1'b0;
      byte_cnt   <= '0;
      overflow   <= 1'b0;
      hold_cnt   <= '0;
      dn_addr    <= '0;
      dn_data    <= '0;
      dn_wr      <= 1'b0;
      dn_region  <= REG_NONE;
      core_reset <= 1'b1;
      rom_ok     <= 1'b0;
      dl_error   <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      dn_wr     <= accept;
      dn_region <= accept ? region : REG_NONE;
      if (accept) begin
        dn_addr <= ioctl_addr[15:0];
        dn_data <= ioctl_dout;
      end

      core_reset <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (dl_rise) begin
            state    <= ST_LOAD;
            byte_cnt <= '0;
            overflow <= 1'b0;
            rom_ok   <= 1'b0;
            dl_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          byte_cnt <= cnt_next;
          overflow <= ovf_next;
          if (dl_fall) begin
            if (cnt_next == CNT_FULL && !ovf_next) begin
              rom_ok   <= 1'b1;
              hold_cnt <= HOLD_LOAD;
              state    <= ST_HOLD;
            end else begin
              dl_error <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (dl_rise) begin
            state    <= ST_LOAD;
            byte_cnt <= '0;
            overflow <= 1'b0;
            rom_ok   <= 1'b0;
            dl_error <= 1'b0;
          end else if (user_reset) begin
            hold_cnt <= HOLD_LOAD;
          end else if (hold_cnt == 16'd0) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        ST_RUN: begin
          if (dl_rise) begin
            state    <= ST_LOAD;
            byte_cnt <= '0;
            overflow <= 1'b0;
            rom_ok   <= 1'b0;
            dl_error <= 1'b0;
          end else if (user_reset) begin
            hold_cnt <= HOLD_LOAD;
            state    <= ST_HOLD;
          end else begin
            core_reset <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_download_sequencer.sv
// tb/tb_rom_download_sequencer.sv - scoreboard bench for rom_download_sequencer
module tb_rom_download_sequencer;

  localparam int TOTAL = 'hE0A0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic [3:0]  region;
    int          due;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        user_reset = 1'b0;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [3:0]  dn_region;
  logic        core_reset;
  logic        rom_ok;
  logic        dl_error;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb[$];

  rom_download_sequencer dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .user_reset     (user_reset),
    .dn_addr        (dn_addr),
    .dn_data        (dn_data),
    .dn_wr          (dn_wr),
    .dn_region      (dn_region),
    .core_reset     (core_reset),
    .rom_ok         (rom_ok),
    .dl_error       (dl_error)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] model_region(input logic [15:0] a);
    if (a < 16'h8000) return 4'b0001;
    if (a < 16'hA000) return 4'b0010;
    if (a < 16'hE000) return 4'b0100;
    return 4'b1000;
  endfunction

  function automatic logic [7:0] byte_of(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  always @(negedge clk_sys) begin
    if (dn_wr) begin
      if (sb.size() == 0) begin
        chk("dn_wr_unexpected", 32'(dn_addr), 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dn_addr", 32'(dn_addr), 32'(e.addr));
        chk("dn_data", 32'(dn_data), 32'(e.data));
        chk("dn_region", 32'(dn_region), 32'(e.region));
        chk("dn_latency", 32'(cyc), 32'(e.due));
      end
    end else begin
      chk("dn_region_idle", 32'(dn_region), 32'd0);
    end
  end

  // Entered and left at posedge+1; drives one ioctl_wr strobe then idles gap cycles.
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input logic [3:0] r,
                         input bit fall, input int gap);
    exp_t e;
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    if (fall) ioctl_download = 1'b0;
    if (a < 25'(TOTAL)) begin
      e.addr = a[15:0]; e.data = d; e.region = r; e.due = cyc + 1;
      sb.push_back(e);
    end
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    repeat (gap) begin @(posedge clk_sys); #1; end
  endtask

  task automatic start_dl();
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
  endtask

  task automatic stop_dl();
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
  endtask

  task automatic wait_release(input string tag, input int ref_cyc, input int exp_dly);
    int d = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_sys);
      if (!core_reset) begin
        d = cyc - ref_cyc;
        break;
      end
    end
    chk(tag, 32'(d), 32'(exp_dly));
    @(posedge clk_sys); #1;
  endtask

  logic [15:0] tbl_addr [6] = '{16'h7FFF, 16'h8000, 16'h9FFF, 16'hA000, 16'hDFFF, 16'hE000};
  logic [3:0]  tbl_reg  [6] = '{4'd1, 4'd2, 4'd2, 4'd4, 4'd4, 4'd8};

  initial begin
    int fall_cyc;
    int drop_cyc;
    int lows;

    // Reset values
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_dn_wr", 32'(dn_wr), 32'd0);
    chk("rst_dn_addr", 32'(dn_addr), 32'd0);
    chk("rst_rom_ok", 32'(rom_ok), 32'd0);
    chk("rst_dl_error", 32'(dl_error), 32'd0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    repeat (4) begin @(posedge clk_sys); #1; end
    chk("idle_core_reset", 32'(core_reset), 32'd1);

    // Full download, last byte written together with the download falling edge
    start_dl();
    fall_cyc = 0;
    for (int a = 0; a < TOTAL; a++) begin
      if (a == TOTAL - 1) begin
        fall_cyc = cyc;
        wr_byte(25'(a), byte_of(16'(a)), model_region(16'(a)), 1'b1, 0);
      end else begin
        wr_byte(25'(a), byte_of(16'(a)), model_region(16'(a)), 1'b0,
                (a < 64 || a >= 'hE060) ? 3 : 0);
      end
    end
    @(negedge clk_sys);
    chk("full_rom_ok", 32'(rom_ok), 32'd1);
    chk("full_dl_error", 32'(dl_error), 32'd0);
    chk("full_hold_core_reset", 32'(core_reset), 32'd1);
    wait_release("full_release_delay", fall_cyc + 1, 16);
    chk("full_sb_empty", 32'(sb.size()), 32'd0);

    // User reset pulse in RUN
    repeat (3) begin @(posedge clk_sys); #1; end
    user_reset = 1'b1;
    @(negedge clk_sys);
    chk("ur_not_early", 32'(core_reset), 32'd0);
    @(posedge clk_sys); #1;
    user_reset = 1'b0;
    drop_cyc = cyc;
    @(negedge clk_sys);
    chk("ur_pulse_rise", 32'(core_reset), 32'd1);
    wait_release("ur_pulse_release", drop_cyc, 16);

    // User reset held 40 clocks
    user_reset = 1'b1;
    repeat (40) begin @(posedge clk_sys); #1; end
    @(negedge clk_sys);
    chk("ur_hold_high", 32'(core_reset), 32'd1);
    @(posedge clk_sys); #1;
    user_reset = 1'b0;
    drop_cyc = cyc;
    wait_release("ur_hold_release", drop_cyc, 16);
    chk("ur_rom_ok_kept", 32'(rom_ok), 32'd1);

    // Short download with region boundary table
    start_dl();
    @(negedge clk_sys);
    chk("reload_rom_ok_clr", 32'(rom_ok), 32'd0);
    chk("reload_core_reset", 32'(core_reset), 32'd1);
    @(posedge clk_sys); #1;
    for (int i = 0; i < 6; i++) wr_byte({9'd0, tbl_addr[i]}, 8'(i + 8'h30), tbl_reg[i], 1'b0, 1);
    stop_dl();
    @(negedge clk_sys);
    chk("short_dl_error", 32'(dl_error), 32'd1);
    chk("short_rom_ok", 32'(rom_ok), 32'd0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (!core_reset) lows++;
    end
    chk("short_core_reset_low_cycles", 32'(lows), 32'd0);
    chk("short_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk_sys); #1;

    // Out-of-range write is dropped and flags an error
    start_dl();
    @(negedge clk_sys);
    chk("ovf_entry_dl_error_clr", 32'(dl_error), 32'd0);
    @(posedge clk_sys); #1;
    for (int a = 0; a < 8; a++) wr_byte(25'(a), byte_of(16'(a)), model_region(16'(a)), 1'b0, 0);
    wr_byte(25'h0E0A0, 8'hEE, 4'd0, 1'b0, 0);
    wr_byte(25'h1000000, 8'hEF, 4'd0, 1'b0, 0);
    wr_byte(25'h8, byte_of(16'h8), model_region(16'h8), 1'b0, 0);
    stop_dl();
    @(negedge clk_sys);
    chk("ovf_dl_error", 32'(dl_error), 32'd1);
    chk("ovf_rom_ok", 32'(rom_ok), 32'd0);
    chk("ovf_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk_sys); #1;

    // Asynchronous reset mid-download
    start_dl();
    wr_byte(25'h2FFF, 8'hA5, model_region(16'h2FFF), 1'b0, 0);
    wr_byte(25'h3000, 8'h3C, model_region(16'h3000), 1'b0, 0);
    @(negedge clk_sys);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_dn_addr", 32'(dn_addr), 32'd0);
    chk("async_dn_data", 32'(dn_data), 32'd0);
    chk("async_dn_wr", 32'(dn_wr), 32'd0);
    chk("async_core_reset", 32'(core_reset), 32'd1);
    chk("async_rom_ok", 32'(rom_ok), 32'd0);
    @(posedge clk_sys); #1;
    reset_n = 1'b1;
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    wr_byte(25'h10, 8'h77, model_region(16'h10), 1'b0, 1);
    wr_byte(25'hE001, 8'h78, model_region(16'hE001), 1'b0, 1);
    stop_dl();
    @(negedge clk_sys);
    chk("post_rst_dl_error", 32'(dl_error), 32'd1);
    chk("post_rst_core_reset", 32'(core_reset), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
